// File: rtl/demosaic_pkg.sv
`default_nettype none
// ============================================================================
// demosaic_pkg : shared encodings for the demosaic stream controller
// Rev 1.0
// ============================================================================
package demosaic_pkg;

   localparam logic [1:0] PH_R  = 2'd0;
   localparam logic [1:0] PH_GR = 2'd1;
   localparam logic [1:0] PH_GB = 2'd2;
   localparam logic [1:0] PH_B  = 2'd3;

   localparam int BAYER_RGGB = 0;
   localparam int BAYER_GRBG = 1;
   localparam int BAYER_GBRG = 2;
   localparam int BAYER_BGGR = 3;

   localparam int ST_W = 3;
   typedef logic [ST_W-1:0] state_t;
   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_GAP        = 3'd1;
   localparam state_t ST_ACTIVE     = 3'd2;
   localparam state_t ST_FLUSH_WAIT = 3'd3;
   localparam state_t ST_FLUSH      = 3'd4;
   localparam state_t ST_DONE       = 3'd5;

   localparam int BRD_TOP    = 3;
   localparam int BRD_BOTTOM = 2;
   localparam int BRD_LEFT   = 1;
   localparam int BRD_RIGHT  = 0;

   // Colour of a site: pattern phase of (0,0) flipped by row/column parity.
   function automatic logic [1:0] bayer_phase(input logic [1:0] pattern,
                                              input logic       row_lsb,
                                              input logic       col_lsb);
      return pattern ^ {row_lsb, col_lsb};
   endfunction

endpackage
`default_nettype wire

// File: rtl/demosaic_win_coord.sv
`default_nettype none
// ============================================================================
// demosaic_win_coord : registers window centre coordinates, phase and borders
// Rev 1.0
// ============================================================================
module demosaic_win_coord
   import demosaic_pkg::*;
#(
   parameter int COLS          = 512,
   parameter int LINES         = 768,
   parameter int CW            = 10,
   parameter int RW            = 10,
   parameter int BAYER_PATTERN = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          raw_valid,
   input  logic [RW-1:0] raw_row,
   input  logic [CW-1:0] raw_col,
   output logic          win_valid,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic [1:0]    phase,
   output logic [3:0]    border,
   output logic          line_valid
);

   localparam logic [CW-1:0] c_last_col = CW'(COLS - 1);
   localparam logic [RW-1:0] c_last_row = RW'(LINES - 1);

   logic          r_valid;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [1:0]    r_phase;
   logic [3:0]    r_border;
   logic [3:0]    w_border;

   always_comb begin
      w_border             = '0;
      w_border[BRD_TOP]    = (raw_row == '0);
      w_border[BRD_BOTTOM] = (raw_row == c_last_row);
      w_border[BRD_LEFT]   = (raw_col == '0);
      w_border[BRD_RIGHT]  = (raw_col == c_last_col);
   end

   // Idle cycles present all-zero coordinates so downstream never sees stale data.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid  <= 1'b0;
         r_row    <= '0;
         r_col    <= '0;
         r_phase  <= '0;
         r_border <= '0;
      end else begin
         r_valid  <= raw_valid;
         r_row    <= raw_valid ? raw_row : '0;
         r_col    <= raw_valid ? raw_col : '0;
         r_phase  <= raw_valid ? bayer_phase(2'(BAYER_PATTERN), raw_row[0], raw_col[0]) : '0;
         r_border <= raw_valid ? w_border : '0;
      end
   end

   assign win_valid  = r_valid;
   assign line_valid = r_valid;
   assign out_row    = r_row;
   assign out_col    = r_col;
   assign phase      = r_phase;
   assign border     = r_border;

endmodule
`default_nettype wire

// File: rtl/demosaic_stream_ctrl.sv
`default_nettype none
// ============================================================================
// demosaic_stream_ctrl : line-buffer sequencing and window timing for demosaic
// Rev 1.0
// ============================================================================
module demosaic_stream_ctrl
   import demosaic_pkg::*;
#(
   parameter int COLS          = 512,
   parameter int LINES         = 768,
   parameter int CW            = 10,
   parameter int RW            = 10,
   parameter int FLUSH_GAP     = 19,
   parameter int BAYER_PATTERN = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          HSYNC,
   input  logic          VSYNC,
   output logic          LB_WE,
   output logic          LB_WSEL,
   output logic [CW-1:0] LB_ADDR,
   output logic          WIN_VALID,
   output logic [RW-1:0] OUT_ROW,
   output logic [CW-1:0] OUT_COL,
   output logic [1:0]    PHASE,
   output logic [3:0]    BORDER,
   output logic          O_HSYNC,
   output logic          O_VSYNC,
   output logic          FRAME_DONE,
   output logic          ERR
);

   localparam int            c_gap_w    = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;
   localparam logic [CW-1:0] c_last_col = CW'(COLS - 1);
   localparam logic [RW-1:0] c_last_row = RW'(LINES - 1);
   localparam logic [CW-1:0] c_col_one  = CW'(1);
   localparam logic [RW-1:0] c_row_one  = RW'(1);
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(FLUSH_GAP - 1);
   localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);

   state_t             r_state;
   state_t             w_next_state;
   logic [RW-1:0]      r_row;
   logic [CW-1:0]      r_col;
   logic               r_full;
   logic               r_wsel;
   logic               r_err;
   logic               r_vsync_d;
   logic               r_o_vsync;
   logic               r_frame_done;
   logic [c_gap_w-1:0] r_gap_cnt;

   logic          w_vs_rise;
   logic          w_in_line;
   logic          w_abort;
   logic          w_write;
   logic          w_line_end;
   logic          w_flush_px;
   logic          w_err_set;
   logic          w_raw_valid;
   logic [RW-1:0] w_raw_row;

   assign w_vs_rise  = VSYNC & ~r_vsync_d;
   assign w_in_line  = (r_state == ST_GAP) || (r_state == ST_ACTIVE);
   assign w_abort    = w_in_line & ~VSYNC;
   assign w_write    = w_in_line & VSYNC & HSYNC & ~r_full;
   assign w_line_end = (r_state == ST_ACTIVE) & VSYNC & ~HSYNC;
   assign w_flush_px = (r_state == ST_FLUSH);
   // Short line, overlong line, early VSYNC drop, or HSYNC while flushing.
   assign w_err_set  = (w_line_end & ~r_full)
                     | (w_in_line & VSYNC & HSYNC & r_full)
                     | w_abort
                     | (HSYNC & ((r_state == ST_FLUSH_WAIT) || (r_state == ST_FLUSH)
                                 || (r_state == ST_DONE)));

   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:       if (w_vs_rise) w_next_state = ST_GAP;
         ST_GAP:        if (!VSYNC) w_next_state = ST_IDLE;
                        else if (HSYNC) w_next_state = ST_ACTIVE;
         ST_ACTIVE:     if (!VSYNC) w_next_state = ST_IDLE;
                        else if (!HSYNC) w_next_state = (r_row == c_last_row) ? ST_FLUSH_WAIT : ST_GAP;
         ST_FLUSH_WAIT: if (r_gap_cnt == c_gap_last) w_next_state = ST_FLUSH;
         ST_FLUSH:      if (r_col == c_last_col) w_next_state = ST_DONE;
         ST_DONE:       w_next_state = ST_IDLE;
         default:       w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      LB_WE       = w_write;
      LB_WSEL     = r_wsel;
      LB_ADDR     = r_col;
      w_raw_valid = (w_write && (r_row != '0)) || w_flush_px;
      w_raw_row   = w_flush_px ? c_last_row : (r_row - c_row_one);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_row        <= '0;
         r_col        <= '0;
         r_full       <= 1'b0;
         r_wsel       <= 1'b0;
         r_err        <= 1'b0;
         r_vsync_d    <= 1'b0;
         r_o_vsync    <= 1'b0;
         r_frame_done <= 1'b0;
         r_gap_cnt    <= '0;
      end else begin
         r_vsync_d    <= VSYNC;
         r_frame_done <= (r_state == ST_DONE);

         if ((r_state == ST_IDLE) && w_vs_rise) r_err <= 1'b0;
         else if (w_err_set)                    r_err <= 1'b1;

         if ((r_state == ST_IDLE) && w_vs_rise)            r_row <= '0;
         else if (w_line_end && (r_row != c_last_row))     r_row <= r_row + c_row_one;

         if (w_line_end) r_wsel <= ~r_wsel;

         // Column saturates at the last pixel; r_full marks a complete line.
         if (w_abort || w_line_end) begin
            r_col  <= '0;
            r_full <= 1'b0;
         end else if (w_write) begin
            if (r_col == c_last_col) r_full <= 1'b1;
            else                     r_col  <= r_col + c_col_one;
         end else if (w_flush_px) begin
            r_col <= (r_col == c_last_col) ? '0 : (r_col + c_col_one);
         end

         if ((r_state == ST_FLUSH_WAIT) && (r_gap_cnt != c_gap_last)) r_gap_cnt <= r_gap_cnt + c_gap_one;
         else                                                         r_gap_cnt <= '0;

         if (w_abort || r_frame_done) r_o_vsync <= 1'b0;
         else if (w_raw_valid)        r_o_vsync <= 1'b1;
      end
   end

   demosaic_win_coord #(
      .COLS          (COLS),
      .LINES         (LINES),
      .CW            (CW),
      .RW            (RW),
      .BAYER_PATTERN (BAYER_PATTERN)
   ) u_win_coord (
      .CLK        (CLK),
      .RST        (RST),
      .raw_valid  (w_raw_valid),
      .raw_row    (w_raw_row),
      .raw_col    (r_col),
      .win_valid  (WIN_VALID),
      .out_row    (OUT_ROW),
      .out_col    (OUT_COL),
      .phase      (PHASE),
      .border     (BORDER),
      .line_valid (O_HSYNC)
   );

   assign O_VSYNC    = r_o_vsync;
   assign FRAME_DONE = r_frame_done;
   assign ERR        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_demosaic_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_demosaic_stream_ctrl : scoreboard bench for the demosaic stream controller
// Rev 1.0
// ============================================================================
module tb_demosaic_stream_ctrl;

   localparam int COLS  = 8;
   localparam int LINES = 4;
   localparam int CW    = 3;
   localparam int RW    = 2;
   localparam int GAP   = 5;

   typedef struct {
      int row;
      int col;
      int gap;
   } win_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic HSYNC = 1'b0;
   logic VSYNC = 1'b0;

   logic          a_we, a_wsel, a_wv, a_ohs, a_ovs, a_fd, a_err;
   logic [CW-1:0] a_addr, a_col;
   logic [RW-1:0] a_row;
   logic [1:0]    a_phase;
   logic [3:0]    a_border;
   logic          b_we, b_wsel, b_wv, b_ohs, b_ovs, b_fd, b_err;
   logic [CW-1:0] b_addr, b_col;
   logic [RW-1:0] b_row;
   logic [1:0]    b_phase;
   logic [3:0]    b_border;

   demosaic_stream_ctrl #(.COLS(COLS), .LINES(LINES), .CW(CW), .RW(RW),
                          .FLUSH_GAP(GAP), .BAYER_PATTERN(0)) dut_a (
      .CLK(CLK), .RST(RST), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .LB_WE(a_we), .LB_WSEL(a_wsel), .LB_ADDR(a_addr), .WIN_VALID(a_wv),
      .OUT_ROW(a_row), .OUT_COL(a_col), .PHASE(a_phase), .BORDER(a_border),
      .O_HSYNC(a_ohs), .O_VSYNC(a_ovs), .FRAME_DONE(a_fd), .ERR(a_err));

   demosaic_stream_ctrl #(.COLS(COLS), .LINES(LINES), .CW(CW), .RW(RW),
                          .FLUSH_GAP(GAP), .BAYER_PATTERN(3)) dut_b (
      .CLK(CLK), .RST(RST), .HSYNC(HSYNC), .VSYNC(VSYNC),
      .LB_WE(b_we), .LB_WSEL(b_wsel), .LB_ADDR(b_addr), .WIN_VALID(b_wv),
      .OUT_ROW(b_row), .OUT_COL(b_col), .PHASE(b_phase), .BORDER(b_border),
      .O_HSYNC(b_ohs), .O_VSYNC(b_ovs), .FRAME_DONE(b_fd), .ERR(b_err));

   always #5 CLK = ~CLK;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_win = -100;
   int   done_pending = 0;
   int   done_seen = 0;
   bit   prev_done = 1'b0;
   int   m_wsel = 0;
   int   lens[LINES];
   win_t exp_win[$];
   int   exp_wr[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int exp_phase(input int pat, input int row, input int col);
      return pat ^ (((row & 1) << 1) | (col & 1));
   endfunction

   function automatic int exp_border(input int row, input int col);
      return (int'(row == 0) << 3) | (int'(row == LINES - 1) << 2)
           | (int'(col == 0) << 1) | int'(col == COLS - 1);
   endfunction

   // Monitor: pops expected writes/windows whenever the DUT presents one.
   always @(negedge CLK) begin
      win_t w;
      int   e;
      cyc++;
      if (a_we) begin
         if (exp_wr.size() == 0) check("lb_we_unexpected", 1, 0);
         else begin
            e = exp_wr.pop_front();
            check("lb_write_sel_addr", int'({a_wsel, a_addr}), e);
         end
      end
      check("o_hsync_tracks_window", int'(a_ohs), int'(a_wv));
      if (a_wv) begin
         if (exp_win.size() == 0) check("win_unexpected", 1, 0);
         else begin
            w = exp_win.pop_front();
            check("win_row", int'(a_row), w.row);
            check("win_col", int'(a_col), w.col);
            check("win_phase_p0", int'(a_phase), exp_phase(0, w.row, w.col));
            check("win_border", int'(a_border), exp_border(w.row, w.col));
            check("win_valid_p3", int'(b_wv), 1);
            check("win_phase_p3", int'(b_phase), exp_phase(3, w.row, w.col));
            if (w.gap > 0) check("win_spacing", cyc - last_win, w.gap);
         end
         check("o_vsync_with_win", int'(a_ovs), 1);
         last_win = cyc;
      end else begin
         check("win_idle_p3", int'(b_wv), 0);
      end
      if (a_fd) begin
         if (done_pending == 0) check("frame_done_unexpected", 1, 0);
         else begin
            done_pending--;
            check("frame_done_latency", cyc - last_win, 1);
            check("frame_done_all_windows", exp_win.size(), 0);
            check("frame_done_o_vsync", int'(a_ovs), 1);
         end
         done_seen++;
      end
      if (prev_done) check("o_vsync_fall", int'(a_ovs), 0);
      prev_done = a_fd;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_win(input int row, input int col, input int gap);
      win_t w;
      w.row = row;
      w.col = col;
      w.gap = gap;
      exp_win.push_back(w);
   endtask

   task automatic drive_line(input int r, input int len);
      for (int c = 0; c < len; c++) begin
         HSYNC = 1'b1;
         if (c < COLS) begin
            exp_wr.push_back(m_wsel * (1 << CW) + c);
            if (r >= 1) push_win(r - 1, c, (c == 0) ? 0 : 1);
         end
         tick();
      end
      HSYNC = 1'b0;
      m_wsel = 1 - m_wsel;
   endtask

   task automatic frame_start(input bit prev_err);
      VSYNC = 1'b0;
      repeat (3) tick();
      check("err_sticky", int'(a_err), int'(prev_err));
      VSYNC = 1'b1;
      tick();
      check("err_clear_on_vsync_rise", int'(a_err), 0);
   endtask

   task automatic run_frame(input int abort_after, input bit hs_in_flush,
                            input bit prev_err, output bit new_err);
      bit exp_err;
      int d0;
      int t;
      exp_err = 1'b0;
      frame_start(prev_err);
      for (int r = 0; r < LINES; r++) begin
         repeat ($urandom_range(1, 4)) tick();
         if (r == abort_after) begin
            VSYNC = 1'b0;
            tick();
            check("abort_o_vsync_low", int'(a_ovs), 0);
            check("abort_err", int'(a_err), 1);
            repeat (COLS + GAP + 6) tick();
            check("abort_queues_empty", exp_wr.size() + exp_win.size(), 0);
            new_err = 1'b1;
            return;
         end
         drive_line(r, lens[r]);
         if (lens[r] != COLS) exp_err = 1'b1;
      end
      for (int c = 0; c < COLS; c++)
         push_win(LINES - 1, c, (c != 0) ? 1 : ((lens[LINES-1] == COLS) ? GAP + 2 : 0));
      done_pending++;
      d0 = done_seen;
      if (hs_in_flush) begin
         tick();
         HSYNC = 1'b1;
         tick();
         tick();
         HSYNC = 1'b0;
         exp_err = 1'b1;
      end
      t = 0;
      while (done_seen == d0 && t < 200) begin
         tick();
         t++;
      end
      check("frame_done_seen", done_seen - d0, 1);
      tick();
      check("err_at_frame_end", int'(a_err), int'(exp_err));
      check("queues_empty", exp_wr.size() + exp_win.size(), 0);
      VSYNC = 1'b0;
      new_err = exp_err;
   endtask

   task automatic set_nominal();
      for (int r = 0; r < LINES; r++) lens[r] = COLS;
   endtask

   initial begin
      bit err;
      HSYNC = 1'b0;
      VSYNC = 1'b0;
      RST = 1'b1;
      repeat (3) tick();
      check("reset_outputs_a", int'({a_we, a_wsel, a_addr, a_wv, a_row, a_col, a_phase,
                                     a_border, a_ohs, a_ovs, a_fd, a_err}), 0);
      check("reset_outputs_b", int'({b_we, b_wsel, b_addr, b_wv, b_row, b_col, b_phase,
                                     b_border, b_ohs, b_ovs, b_fd, b_err}), 0);
      RST = 1'b0;
      tick();

      set_nominal();
      run_frame(LINES, 1'b0, 1'b0, err);

      lens[2] = 6;
      run_frame(LINES, 1'b0, err, err);
      set_nominal();
      run_frame(LINES, 1'b0, err, err);

      run_frame(2, 1'b0, err, err);

      run_frame(LINES, 1'b1, err, err);

      // Reset in the middle of line 1 while windows are streaming.
      frame_start(err);
      tick();
      drive_line(0, COLS);
      repeat (2) tick();
      drive_line(1, 3);
      RST = 1'b1;
      VSYNC = 1'b0;
      tick();
      check("midframe_reset_outputs", int'({a_we, a_wsel, a_addr, a_wv, a_row, a_col, a_phase,
                                            a_border, a_ohs, a_ovs, a_fd, a_err}), 0);
      check("midframe_reset_queues", exp_wr.size() + exp_win.size(), 0);
      RST = 1'b0;
      m_wsel = 0;
      repeat (COLS + GAP + 4) tick();
      set_nominal();
      run_frame(LINES, 1'b0, 1'b0, err);

      for (int f = 0; f < 6; f++) begin
         for (int r = 0; r < LINES; r++)
            lens[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(COLS - 3, COLS + 2)) : COLS;
         run_frame(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, LINES - 1)) : LINES,
                   1'($urandom_range(0, 1)), err, err);
      end

      repeat (4) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
